// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and default sizing for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

    // Sequencer states; encoding 3 is unused and decays to RUN.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } ctrl_state_t;

    localparam int unsigned CNT_W_DEF       = 32;
    localparam int unsigned MEM_TIMEOUT_DEF = 255;
    localparam int unsigned TO_W_DEF        = $clog2(MEM_TIMEOUT_DEF + 1);

    // Width needed to hold a wait count up to and including the timeout value.
    function automatic int unsigned wait_cnt_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Count register: clear wins over increment, increment stops at the maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: priority decoder for stage enables/flushes,
// a small FSM for data-memory waits and redirect bubbles, and statistics.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hz_fe_enable,
    input  logic             hz_if_id_clear,
    input  logic             hz_id_ex_clear,
    input  logic             ex_redirect,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             pc_sel_redirect,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    localparam int unsigned     TO_W    = wait_cnt_width(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    ctrl_state_t     r_state;
    ctrl_state_t     w_state_nxt;
    logic            r_redir_pend;
    logic            w_redir_pend_nxt;
    logic            r_mem_timeout;
    logic            w_freeze;
    logic            w_redir_accept;
    logic            w_wait_inc;
    logic [TO_W-1:0] w_wait_cnt;

    // The whole pipeline freezes while the data memory has not answered.
    assign w_freeze       = dmem_req && !dmem_ready;
    // EX is held during a freeze, so a redirect is only taken once released.
    assign w_redir_accept = ex_redirect && !w_freeze;
    assign w_wait_inc     = (r_state == MEM_WAIT) && w_freeze;

    // State register plus the "redirect bubble still owed" marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RUN;
            r_redir_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_redir_pend <= w_redir_pend_nxt;
        end
    end

    // Next-state logic; a freeze in REDIRECT remembers the bubble for after the wait.
    always_comb begin
        w_state_nxt      = RUN;
        w_redir_pend_nxt = r_redir_pend;
        case (r_state)
            RUN: begin
                if (w_freeze) begin
                    w_state_nxt = MEM_WAIT;
                end else if (w_redir_accept) begin
                    w_state_nxt = REDIRECT;
                end
            end
            MEM_WAIT: begin
                if (w_freeze) begin
                    w_state_nxt = MEM_WAIT;
                end else begin
                    w_redir_pend_nxt = 1'b0;
                    if (ex_redirect || r_redir_pend) begin
                        w_state_nxt = REDIRECT;
                    end
                end
            end
            REDIRECT: begin
                if (w_freeze) begin
                    w_state_nxt      = MEM_WAIT;
                    w_redir_pend_nxt = 1'b1;
                end else if (w_redir_accept) begin
                    w_state_nxt = REDIRECT;
                end
            end
            default: begin
                w_state_nxt      = RUN;
                w_redir_pend_nxt = 1'b0;
            end
        endcase
    end

    // Priority decoder for enables/flushes; reset forces every stage to a bubble.
    always_comb begin
        pc_en           = 1'b1;
        pc_sel_redirect = 1'b0;
        if_id_en        = 1'b1;
        id_ex_en        = 1'b1;
        ex_mem_en       = 1'b1;
        mem_wb_en       = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        mem_wb_flush    = 1'b0;

        if (w_freeze) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (ex_redirect) begin
            pc_sel_redirect = 1'b1;
            if_id_flush     = 1'b1;
            id_ex_flush     = 1'b1;
        end else if (r_state == REDIRECT) begin
            pc_en       = imem_ready;
            if_id_flush = 1'b1;
        end else if (hz_id_ex_clear) begin
            // IF/ID is held, not flushed, so the stalled instruction survives.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (hz_if_id_clear || !hz_fe_enable) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
        end else if (!imem_ready) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
        end

        // Leaving MEM_WAIT: MEM/WB already captured this result once.
        if ((r_state == MEM_WAIT) && !w_freeze) begin
            mem_wb_flush = 1'b1;
            mem_wb_en    = 1'b1;
        end

        if (!rst_n) begin
            pc_en           = 1'b0;
            pc_sel_redirect = 1'b0;
            if_id_en        = 1'b0;
            id_ex_en        = 1'b0;
            ex_mem_en       = 1'b0;
            mem_wb_en       = 1'b0;
            if_id_flush     = 1'b1;
            id_ex_flush     = 1'b1;
            mem_wb_flush    = 1'b1;
        end
    end

    // Sticky timeout flag: sets on the edge where the wait count reaches the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_timeout <= 1'b0;
        end else if (w_wait_inc && (w_wait_cnt == TO_LAST)) begin
            r_mem_timeout <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (!pc_en),
        .i_clr (1'b0),
        .o_cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_redir_accept),
        .i_clr (1'b0),
        .o_cnt (flush_cnt)
    );

    sat_counter #(.W(TO_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_wait_inc),
        .i_clr (!w_wait_inc),
        .o_cnt (w_wait_cnt)
    );

    assign ctrl_state  = r_state;
    assign mem_timeout = r_mem_timeout;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with small counters and a short timeout.
module tb_pipeline_ctrl;

    localparam int unsigned CNT_W       = 3;
    localparam int unsigned MEM_TIMEOUT = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             hz_fe_enable, hz_if_id_clear, hz_id_ex_clear, ex_redirect;
    logic             imem_ready, dmem_req, dmem_ready;
    logic             pc_en, pc_sel_redirect;
    logic             if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic             if_id_flush, id_ex_flush, mem_wb_flush;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             mem_timeout;

    int total = 0;
    int bad   = 0;

    pipeline_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .hz_fe_enable    (hz_fe_enable),
        .hz_if_id_clear  (hz_if_id_clear),
        .hz_id_ex_clear  (hz_id_ex_clear),
        .ex_redirect     (ex_redirect),
        .imem_ready      (imem_ready),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .pc_en           (pc_en),
        .pc_sel_redirect (pc_sel_redirect),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .mem_wb_flush    (mem_wb_flush),
        .ctrl_state      (ctrl_state),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .mem_timeout     (mem_timeout)
    );

    always #5 clk = ~clk;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}
    wire [4:0] w_en = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
    // {if_id_flush, id_ex_flush, mem_wb_flush}
    wire [2:0] w_fl = {if_id_flush, id_ex_flush, mem_wb_flush};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hz_fe_enable   = 1'b1;
        hz_if_id_clear = 1'b0;
        hz_id_ex_clear = 1'b0;
        ex_redirect    = 1'b0;
        imem_ready     = 1'b1;
        dmem_req       = 1'b0;
        dmem_ready     = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #3;
        check("rst_en", 32'(w_en), 32'h00);
        check("rst_fl", 32'(w_fl), 32'h7);
        check("rst_sel", 32'(pc_sel_redirect), 32'h0);
        check("rst_state", 32'(ctrl_state), 32'h0);
        check("rst_stall", 32'(stall_cnt), 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        check("idle_en", 32'(w_en), 32'h1f);
        check("idle_fl", 32'(w_fl), 32'h0);
        repeat (10) tick();
        check("idle_stall", 32'(stall_cnt), 32'h0);

        // Load-use
        hz_id_ex_clear = 1'b1;
        #1;
        check("lu_en", 32'(w_en), 32'h07);
        check("lu_fl", 32'(w_fl), 32'h2);
        tick();
        hz_id_ex_clear = 1'b0;
        check("lu_stall", 32'(stall_cnt), 32'h1);

        // Control hazard then taken branch
        hz_if_id_clear = 1'b1;
        #1;
        check("ch_en", 32'(w_en), 32'h0f);
        check("ch_fl", 32'(w_fl), 32'h4);
        tick();
        hz_if_id_clear = 1'b0;
        ex_redirect    = 1'b1;
        #1;
        check("br_sel", 32'(pc_sel_redirect), 32'h1);
        check("br_en", 32'(w_en), 32'h1f);
        check("br_fl", 32'(w_fl), 32'h6);
        tick();
        ex_redirect = 1'b0;
        #1;
        check("br2_state", 32'(ctrl_state), 32'h2);
        check("br2_fl", 32'(w_fl), 32'h4);
        check("br2_en", 32'(w_en), 32'h1f);
        check("br2_flushcnt", 32'(flush_cnt), 32'h1);
        check("br2_stall", 32'(stall_cnt), 32'h2);
        tick();
        check("br3_state", 32'(ctrl_state), 32'h0);
        check("br3_fl", 32'(w_fl), 32'h0);

        // Data wait with a redirect held in EX
        dmem_req    = 1'b1;
        ex_redirect = 1'b1;
        dmem_ready  = 1'b0;
        #1;
        check("dw_en", 32'(w_en), 32'h00);
        check("dw_fl", 32'(w_fl), 32'h0);
        check("dw_sel", 32'(pc_sel_redirect), 32'h0);
        repeat (3) tick();
        check("dw_state", 32'(ctrl_state), 32'h1);
        check("dw_en3", 32'(w_en), 32'h00);
        check("dw_flushcnt", 32'(flush_cnt), 32'h1);
        check("dw_stall", 32'(stall_cnt), 32'h5);
        dmem_ready = 1'b1;
        #1;
        check("dw_rel_sel", 32'(pc_sel_redirect), 32'h1);
        check("dw_rel_fl", 32'(w_fl), 32'h7);
        check("dw_rel_en", 32'(w_en), 32'h1f);
        tick();
        idle_inputs();
        check("dw_post_state", 32'(ctrl_state), 32'h2);
        check("dw_post_flushcnt", 32'(flush_cnt), 32'h2);
        tick();
        check("dw_back_run", 32'(ctrl_state), 32'h0);

        // Timeout
        do_reset();
        dmem_req   = 1'b1;
        dmem_ready = 1'b0;
        tick();
        repeat (3) tick();
        check("to_before", 32'(mem_timeout), 32'h0);
        tick();
        check("to_set", 32'(mem_timeout), 32'h1);
        check("to_state", 32'(ctrl_state), 32'h1);
        dmem_ready = 1'b1;
        tick();
        idle_inputs();
        tick();
        check("to_sticky", 32'(mem_timeout), 32'h1);
        check("to_run", 32'(ctrl_state), 32'h0);
        rst_n = 1'b0;
        #1;
        check("to_rst", 32'(mem_timeout), 32'h0);

        // Stall counter saturation
        tick();
        rst_n      = 1'b1;
        imem_ready = 1'b0;
        #1;
        check("miss_en", 32'(w_en), 32'h0f);
        check("miss_fl", 32'(w_fl), 32'h4);
        repeat (10) tick();
        check("sat_stall", 32'(stall_cnt), 32'h7);

        // Reset in the middle of a data wait
        imem_ready = 1'b1;
        dmem_req   = 1'b1;
        dmem_ready = 1'b0;
        tick();
        tick();
        check("mw_state", 32'(ctrl_state), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mw_rst_state", 32'(ctrl_state), 32'h0);
        check("mw_rst_stall", 32'(stall_cnt), 32'h0);
        check("mw_rst_fl", 32'(w_fl), 32'h7);
        idle_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        check("mw_after_state", 32'(ctrl_state), 32'h0);
        check("mw_after_en", 32'(w_en), 32'h1f);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
